// File: rtl/nbody_readback.sv
`default_nettype none
// ============================================================================
// nbody_readback : drains N_BODIES and selected per-body fields from the
//                  nbody register file onto a valid/ready stream.  rev 1.0
// ============================================================================
module nbody_readback #(
  parameter int          BODY_ADDR_WIDTH = 9,
  parameter int          READ_LATENCY    = 1,
  parameter logic [15:0] NBODIES_ADDR    = 16'h0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  field_mask,
  output logic        busy,
  output logic        done,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [15:0] m_addr,
  output logic [63:0] m_writedata,
  input  logic [63:0] m_readdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [8:0]  out_body,
  output logic [2:0]  out_field,
  output logic        out_last
);

  localparam int BW   = BODY_ADDR_WIDTH;
  localparam int CW   = BODY_ADDR_WIDTH + 1;
  localparam int LW   = $clog2(READ_LATENCY + 1);
  localparam int MAXN = 2 ** BODY_ADDR_WIDTH;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_N   = 3'd1;
  localparam logic [2:0] S_WAIT_N = 3'd2;
  localparam logic [2:0] S_RD_F   = 3'd3;
  localparam logic [2:0] S_WAIT_F = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;
  localparam logic [2:0] S_FIN    = 3'd6;

  logic [2:0]    state, state_nxt;
  logic [4:0]    mask;
  logic [CW-1:0] n;
  logic [BW-1:0] body;
  logic [2:0]    idx;
  logic [LW-1:0] lat;
  logic [63:0]   data_q;
  logic [8:0]    body_q;
  logic [2:0]    field_q;
  logic          last_q;

  logic          lat_done;
  logic [CW-1:0] n_cap;
  logic [4:0]    above;
  logic [2:0]    first_idx, last_idx, next_idx;
  logic [2:0]    sel;

  // Field index order is X, Y, VX, VY, M, which matches the mask bit order.
  function automatic logic [2:0] low_set(input logic [4:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 4; i >= 0; i--) if (m[i]) r = 3'(i);
    return r;
  endfunction

  function automatic logic [2:0] high_set(input logic [4:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 5; i++) if (m[i]) r = 3'(i);
    return r;
  endfunction

  function automatic logic [2:0] sel_of(input logic [2:0] i);
    case (i)
      3'd0:    return 3'd3;
      3'd1:    return 3'd4;
      3'd2:    return 3'd6;
      3'd3:    return 3'd7;
      default: return 3'd5;
    endcase
  endfunction

  assign lat_done  = (lat == LW'(READ_LATENCY));
  assign n_cap     = (m_readdata > 64'(MAXN)) ? CW'(MAXN) : m_readdata[CW-1:0];
  assign above     = mask & (5'b11111 << (idx + 3'd1));
  assign first_idx = low_set(mask);
  assign last_idx  = high_set(mask);
  assign next_idx  = low_set(above);
  assign sel       = sel_of(idx);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_RD_N;
      S_RD_N:   state_nxt = S_WAIT_N;
      S_WAIT_N: if (lat_done)
                  state_nxt = (n_cap == '0 || mask == 5'd0) ? S_FIN : S_RD_F;
      S_RD_F:   state_nxt = S_WAIT_F;
      S_WAIT_F: if (lat_done) state_nxt = S_OUT;
      S_OUT:    if (out_ready) state_nxt = last_q ? S_FIN : S_RD_F;
      S_FIN:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != S_IDLE) && (state != S_FIN);
    done         = (state == S_FIN);
    m_read       = (state == S_RD_N) || (state == S_RD_F);
    m_chipselect = m_read;
    m_addr       = 16'h0000;
    if (state == S_RD_N) m_addr = NBODIES_ADDR;
    if (state == S_RD_F) m_addr = {4'b0000, sel, 9'(body)};
    out_valid    = (state == S_OUT);
    out_last     = out_valid & last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask    <= 5'd0;
      n       <= '0;
      body    <= '0;
      idx     <= 3'd0;
      lat     <= '0;
      data_q  <= 64'd0;
      body_q  <= 9'd0;
      field_q <= 3'd0;
      last_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) mask <= field_mask;
        S_RD_N, S_RD_F: lat <= LW'(1);
        S_WAIT_N: begin
          lat <= lat + LW'(1);
          if (lat_done) begin
            n    <= n_cap;
            body <= '0;
            idx  <= first_idx;
          end
        end
        S_WAIT_F: begin
          lat <= lat + LW'(1);
          if (lat_done) begin
            data_q  <= m_readdata;
            body_q  <= 9'(body);
            field_q <= sel;
            last_q  <= ({1'b0, body} == n - CW'(1)) && (idx == last_idx);
          end
        end
        S_OUT: begin
          // After the final word the iterator is left alone; FIN follows.
          if (out_ready && !last_q) begin
            if (above != 5'd0) begin
              idx <= next_idx;
            end else begin
              body <= body + BW'(1);
              idx  <= first_idx;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign m_write     = 1'b0;
  assign m_writedata = 64'd0;
  assign out_data    = data_q;
  assign out_body    = body_q;
  assign out_field   = field_q;

endmodule
`default_nettype wire

// File: tb/tb_nbody_readback.sv
`default_nettype none
// ============================================================================
// tb_nbody_readback : directed bench with a latency-1 slave model. rev 1.0
// ============================================================================
module tb_nbody_readback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  field_mask = 5'd0;
  logic        busy, done, m_chipselect, m_read, m_write;
  logic [15:0] m_addr;
  logic [63:0] m_writedata;
  logic [63:0] m_readdata = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [8:0]  out_body;
  logic [2:0]  out_field;
  logic        out_last;

  int checks = 0;
  int failures = 0;
  logic [63:0] n_val = 64'd0;

  nbody_readback dut (
    .clk(clk), .rst(rst), .start(start), .field_mask(field_mask),
    .busy(busy), .done(done), .m_chipselect(m_chipselect), .m_read(m_read),
    .m_write(m_write), .m_addr(m_addr), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_body(out_body), .out_field(out_field),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] data_of(input logic [15:0] a);
    if (a == 16'h0400) return n_val;
    if (a == 16'h0600) return 64'h3FF0000000000000;   // body0 X = 1.0
    if (a == 16'h0800) return 64'h4024000000000000;   // body0 Y = 10.0
    return {48'hC0DE_5EED_0000, a};
  endfunction

  // Slave: data is valid exactly one cycle after the read cycle, garbage otherwise.
  always @(posedge clk)
    m_readdata <= m_read ? data_of(m_addr) : 64'hDEAD_BEEF_DEAD_BEEF;

  function automatic logic [2:0] sel_of(input int i);
    case (i)
      0: return 3'd3;
      1: return 3'd4;
      2: return 3'd6;
      3: return 3'd7;
      default: return 3'd5;
    endcase
  endfunction

  function automatic int next_in(input logic [4:0] m, input int from);
    for (int i = from; i < 5; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_read"}, {63'd0, m_read}, 64'd0);
    check({tag, "_cs"}, {63'd0, m_chipselect}, 64'd0);
    check({tag, "_addr"}, 64'(m_addr), 64'd0);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_data"}, out_data, 64'd0);
    check({tag, "_body"}, 64'(out_body), 64'd0);
    check({tag, "_field"}, 64'(out_field), 64'd0);
    check({tag, "_last"}, 64'(out_last), 64'd0);
    check({tag, "_wr"}, {63'd0, m_write}, 64'd0);
    check({tag, "_wdata"}, m_writedata, 64'd0);
  endtask

  task automatic run(input logic [63:0] n, input logic [4:0] mask,
                     input int stall_word, input int stall_len, input int rst_word);
    int nb, nf, total, words, reads, dones, stall_left, e_body, e_idx, nxt, cyc;
    logic [15:0] e_addr;
    logic aborted;
    nb = (n > 64'd512) ? 512 : int'(n);
    nf = $countones(mask);
    total = (mask == 5'd0) ? 0 : nb * nf;
    words = 0; reads = 0; dones = 0; stall_left = stall_len; aborted = 1'b0;
    e_body = 0; e_idx = next_in(mask, 0);
    n_val = n;
    @(negedge clk);
    start = 1'b1; field_mask = mask; out_ready = 1'b1;
    for (cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      start = 1'b0; field_mask = 5'd0;
      if (cyc == 0) check("busy_after_start", 64'(busy), 64'd1);
      e_addr = {4'b0000, sel_of(e_idx), 9'(e_body)};
      if (m_read) begin
        check("cs_eq_read", {63'd0, m_chipselect}, 64'd1);
        check("read_while_valid", 64'(out_valid), 64'd0);
        if (reads == 0) check("addr_nbodies", 64'(m_addr), 64'h0400);
        else            check("addr_field", 64'(m_addr), 64'(e_addr));
        reads++;
      end
      if (done) begin
        dones++;
        check("busy_at_done", 64'(busy), 64'd0);
        check("words_at_done", 64'(words), 64'(total));
        break;
      end
      if (out_valid && words == rst_word) begin
        rst = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("after_rst");
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("no_done_after_rst", 64'(done), 64'd0);
        end
        aborted = 1'b1;
        break;
      end
      if (out_valid) begin
        if (words == stall_word && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
          check("stall_data", out_data, data_of(e_addr));
          check("stall_body", 64'(out_body), 64'(e_body));
        end else begin
          out_ready = 1'b1;
          nxt = next_in(mask, e_idx + 1);
          check("out_body", 64'(out_body), 64'(e_body));
          check("out_field", 64'(out_field), 64'(sel_of(e_idx)));
          check("out_data", out_data, data_of(e_addr));
          check("out_last", 64'(out_last), 64'((e_body == nb - 1) && (nxt < 0)));
          if (nxt >= 0) e_idx = nxt;
          else begin e_body++; e_idx = next_in(mask, 0); end
          words++;
        end
      end else begin
        out_ready = 1'b1;
      end
    end
    if (cyc >= 20000) check("timeout", 64'd0, 64'd1);
    out_ready = 1'b1;
    if (!aborted) begin
      @(negedge clk);
      check("done_single", 64'(done), 64'd0);
      check("read_count", 64'(reads), 64'(total + 1));
      check("done_count", 64'(dones), 64'd1);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("start_ignored_idle_busy", 64'(busy), 64'd0);

    run(64'd3,    5'b11111, -1, 0, -1);  // 15 words incl. 1.0 / 10.0 for body0
    run(64'd21,   5'b00011, -1, 0, -1);  // X/Y only, last body 20 field 4
    run(64'd0,    5'b11111, -1, 0, -1);  // single N_BODIES read, no words
    run(64'd4,    5'b11111,  1, 7, -1);  // 7-cycle stall on word 2
    run(64'd1000, 5'b10000, -1, 0, -1);  // clamps to 512 bodies
    run(64'd6,    5'b11111, -1, 0,  3);  // reset while word 4 is presented
    run(64'd2,    5'b00101, -1, 0, -1);  // fresh start re-reads 0x0400

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
